// File: rtl/shifter_pkg.sv
// shifter_pkg: op encoding and level-to-stage mapping shared by the barrel pipeline.
package shifter_pkg;

  typedef enum logic [2:0] {
    OP_SLL = 3'd0,
    OP_SRL = 3'd1,
    OP_SRA = 3'd2,
    OP_ROL = 3'd3,
    OP_ROR = 3'd4
  } op_e;

  function automatic int stage_of_level(input int k, input int stages, input int shamt_w);
    return (k * stages) / shamt_w;
  endfunction

endpackage

// File: rtl/shift_stage.sv
// shift_stage: the barrel levels owned by one pipeline stage plus its register bank.
module shift_stage import shifter_pkg::*; #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5,
  parameter int TAG_W   = 4,
  parameter int STAGES  = 2,
  parameter int IDX     = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_advance,
  input  logic               i_valid,
  input  logic               i_err,
  input  logic [WIDTH-1:0]   i_data,
  input  logic [SHAMT_W-1:0] i_shamt,
  input  logic [2:0]         i_op,
  input  logic [TAG_W-1:0]   i_tag,
  output logic               o_valid,
  output logic               o_err,
  output logic [WIDTH-1:0]   o_data,
  output logic [SHAMT_W-1:0] o_shamt,
  output logic [2:0]         o_op,
  output logic [TAG_W-1:0]   o_tag
);

  logic [WIDTH-1:0] w_data;

  function automatic logic [WIDTH-1:0] shift_level(input logic [WIDTH-1:0] d, input logic [2:0] op,
                                                   input int a);
    return op == OP_SRL ? d >> a :
           op == OP_SRA ? WIDTH'($signed(d) >>> a) :
           op == OP_ROL ? (d << a) | (d >> (WIDTH - a)) :
           op == OP_ROR ? (d >> a) | (d << (WIDTH - a)) :
                          d << a;
  endfunction

  always_comb begin
    w_data = i_data;
    for (int k = 0; k < SHAMT_W; k++)
      if (stage_of_level(k, STAGES, SHAMT_W) == IDX && i_shamt[k])
        w_data = shift_level(w_data, i_op, 1 << k);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_valid <= 1'b0;
      o_err   <= 1'b0;
      o_data  <= '0;
      o_shamt <= '0;
      o_op    <= '0;
      o_tag   <= '0;
    end else if (i_advance) begin
      o_valid <= i_valid;
      o_err   <= i_err;
      o_data  <= w_data;
      o_shamt <= i_shamt;
      o_op    <= i_op;
      o_tag   <= i_tag;
    end
  end

endmodule

// File: rtl/pipelined_shifter.sv
// pipelined_shifter: logarithmic shift/rotate network split over STAGES register banks
// with valid/ready flow control that stalls the whole pipe together.
module pipelined_shifter import shifter_pkg::*; #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int TAG_W  = 4,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [2:0]         in_op,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [TAG_W-1:0]   out_tag,
  output logic               out_err,
  output logic               busy
);

  logic               w_valid [0:STAGES];
  logic               w_err   [0:STAGES];
  logic [WIDTH-1:0]   w_data  [0:STAGES];
  logic [SHAMT_W-1:0] w_shamt [0:STAGES];
  logic [2:0]         w_op    [0:STAGES];
  logic [TAG_W-1:0]   w_tag   [0:STAGES];
  logic [STAGES-1:0]  w_busy;
  logic               w_advance;
  logic               w_reserved;
  logic               w_unused;

  assign w_advance  = !out_valid || out_ready;
  assign in_ready   = w_advance;
  assign w_reserved = in_op > 3'd4;

  // Reserved ops enter as a zero operand so every level passes zero through.
  assign w_valid[0] = in_valid;
  assign w_err[0]   = w_reserved;
  assign w_data[0]  = w_reserved ? '0 : in_data;
  assign w_shamt[0] = in_shamt;
  assign w_op[0]    = w_reserved ? OP_SLL : in_op;
  assign w_tag[0]   = in_tag;

  genvar s;
  generate
    for (s = 0; s < STAGES; s++) begin : g_stage
      shift_stage #(
        .WIDTH(WIDTH), .SHAMT_W(SHAMT_W), .TAG_W(TAG_W), .STAGES(STAGES), .IDX(s)
      ) u_stage (
        .clk(clk),
        .rst_n(rst_n),
        .i_advance(w_advance),
        .i_valid(w_valid[s]),
        .i_err(w_err[s]),
        .i_data(w_data[s]),
        .i_shamt(w_shamt[s]),
        .i_op(w_op[s]),
        .i_tag(w_tag[s]),
        .o_valid(w_valid[s+1]),
        .o_err(w_err[s+1]),
        .o_data(w_data[s+1]),
        .o_shamt(w_shamt[s+1]),
        .o_op(w_op[s+1]),
        .o_tag(w_tag[s+1])
      );
      assign w_busy[s] = w_valid[s+1];
    end
  endgenerate

  assign out_valid = w_valid[STAGES];
  assign out_err   = w_err[STAGES];
  assign out_data  = w_data[STAGES];
  assign out_tag   = w_tag[STAGES];
  assign busy      = |w_busy;
  assign w_unused  = ^{w_shamt[STAGES], w_op[STAGES]};

endmodule

// File: tb/tb_pipelined_shifter.sv
// tb_pipelined_shifter: directed checks of shifts, rotations, flow control and reset.
module tb_pipelined_shifter;

  logic        clk = 0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, out_err, busy;
  logic [31:0] in_data, out_data;
  logic [4:0]  in_shamt;
  logic [2:0]  in_op;
  logic [3:0]  in_tag, out_tag;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipelined_shifter #(.WIDTH(32), .STAGES(2), .TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_shamt(in_shamt), .in_op(in_op), .in_tag(in_tag), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag), .out_err(out_err), .busy(busy)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic run_op(input logic [2:0] op, input logic [31:0] d, input logic [4:0] sh,
                        input logic [3:0] tg, output logic [31:0] rd, output logic [3:0] rt,
                        output logic re, output int lat);
    in_valid = 1; in_op = op; in_data = d; in_shamt = sh; in_tag = tg;
    @(posedge clk);
    @(negedge clk);
    in_valid = 0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid) lat = -1;
    rd = out_data; rt = out_tag; re = out_err;
  endtask

  task automatic test_reset;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (out_data !== 32'h0) begin failures++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
    checks++; if (out_tag !== 4'h0) begin failures++; $display("FAIL reset_out_tag got=%h exp=0", out_tag); end
    checks++; if (out_err !== 1'b0) begin failures++; $display("FAIL reset_out_err got=%b exp=0", out_err); end
    @(negedge clk);
    rst_n = 1;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    @(negedge clk);
  endtask

  task automatic test_sll_srl;
    logic [31:0] d; logic [3:0] t; logic e; int lat;
    run_op(3'd0, 32'h12345678, 5'd5, 4'h1, d, t, e, lat);
    checks++; if (d !== 32'h468ACF00) begin failures++; $display("FAIL sll_data got=%h exp=468acf00", d); end
    checks++; if (lat !== 2) begin failures++; $display("FAIL sll_latency got=%0d exp=2", lat); end
    checks++; if (e !== 1'b0) begin failures++; $display("FAIL sll_err got=%b exp=0", e); end
    run_op(3'd1, 32'h12345678, 5'd2, 4'h2, d, t, e, lat);
    checks++; if (d !== 32'h048D159E) begin failures++; $display("FAIL srl_data got=%h exp=048d159e", d); end
    checks++; if (lat !== 2) begin failures++; $display("FAIL srl_latency got=%0d exp=2", lat); end
    checks++; if (t !== 4'h2) begin failures++; $display("FAIL srl_tag got=%h exp=2", t); end
  endtask

  task automatic test_sra_rot;
    logic [31:0] d; logic [3:0] t; logic e; int lat;
    run_op(3'd2, 32'h80000000, 5'd4, 4'h3, d, t, e, lat);
    checks++; if (d !== 32'hF8000000) begin failures++; $display("FAIL sra_data got=%h exp=f8000000", d); end
    run_op(3'd4, 32'h12345678, 5'd4, 4'h4, d, t, e, lat);
    checks++; if (d !== 32'h81234567) begin failures++; $display("FAIL ror_data got=%h exp=81234567", d); end
    run_op(3'd3, 32'h12345678, 5'd8, 4'h5, d, t, e, lat);
    checks++; if (d !== 32'h34567812) begin failures++; $display("FAIL rol_data got=%h exp=34567812", d); end
    run_op(3'd3, 32'h80000001, 5'd31, 4'h6, d, t, e, lat);
    checks++; if (d !== 32'hC0000000) begin failures++; $display("FAIL rol31_data got=%h exp=c0000000", d); end
  endtask

  task automatic test_zero_shamt;
    logic [31:0] d; logic [3:0] t; logic e; int lat;
    for (int op = 0; op < 5; op++) begin
      run_op(3'(op), 32'hDEADBEEF, 5'd0, 4'(op), d, t, e, lat);
      checks++; if (d !== 32'hDEADBEEF) begin failures++; $display("FAIL zero_shamt_op%0d got=%h exp=deadbeef", op, d); end
      checks++; if (e !== 1'b0) begin failures++; $display("FAIL zero_shamt_err_op%0d got=%b exp=0", op, e); end
    end
  endtask

  task automatic test_reserved;
    logic [31:0] d; logic [3:0] t; logic e; int lat;
    run_op(3'd6, 32'hFFFFFFFF, 5'd3, 4'hA, d, t, e, lat);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL reserved_data got=%h exp=0", d); end
    checks++; if (e !== 1'b1) begin failures++; $display("FAIL reserved_err got=%b exp=1", e); end
    checks++; if (t !== 4'hA) begin failures++; $display("FAIL reserved_tag got=%h exp=a", t); end
  endtask

  task automatic test_back_to_back;
    int nxt = 1, exp = 1, low = 0;
    logic held = 0;
    logic [31:0] hd;
    logic [3:0] ht;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      out_ready = !(c >= 2 && c <= 4);
      in_valid = nxt <= 4; in_op = 3'd0; in_data = 32'h1; in_shamt = 5'(nxt); in_tag = 4'(nxt);
      #1;
      if (held) begin
        checks++; if (out_valid !== 1'b1 || out_data !== hd || out_tag !== ht) begin
          failures++; $display("FAIL stall_stable cyc=%0d got=%b/%h/%h exp=1/%h/%h", c, out_valid, out_data, out_tag, hd, ht);
        end
      end
      if (!in_ready) low++;
      if (out_valid && out_ready) begin
        checks++; if (out_tag !== 4'(exp) || out_data !== (32'h1 << exp)) begin
          failures++; $display("FAIL order tag got=%h data=%h exp tag=%0d data=%h", out_tag, out_data, exp, 32'h1 << exp);
        end
        exp++;
      end
      held = out_valid && !out_ready; hd = out_data; ht = out_tag;
      if (in_valid && in_ready) nxt++;
    end
    in_valid = 0; out_ready = 1;
    checks++; if (exp !== 5) begin failures++; $display("FAIL b2b_count got=%0d exp=4", exp - 1); end
    checks++; if (low !== 3) begin failures++; $display("FAIL in_ready_low_cycles got=%0d exp=3", low); end
    @(negedge clk);
  endtask

  task automatic test_reset_midflight;
    int seen = 0;
    in_valid = 1; in_op = 3'd0; in_data = 32'h5; in_shamt = 5'd1; in_tag = 4'h5;
    @(posedge clk);
    @(negedge clk);
    in_tag = 4'h6;
    @(posedge clk);
    @(negedge clk);
    in_valid = 0;
    #1;
    checks++; if (busy !== 1'b1 || out_valid !== 1'b1) begin failures++; $display("FAIL inflight busy/valid got=%b/%b exp=1/1", busy, out_valid); end
    rst_n = 0;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midreset_out_valid got=%b exp=0", out_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midreset_busy got=%b exp=0", busy); end
    @(negedge clk);
    rst_n = 1;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL release_in_ready got=%b exp=1", in_ready); end
    repeat (6) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    checks++; if (seen !== 0) begin failures++; $display("FAIL post_reset_emits got=%0d exp=0", seen); end
  endtask

  initial begin
    rst_n = 0; in_valid = 0; in_data = 0; in_shamt = 0; in_op = 0; in_tag = 0; out_ready = 1;
    repeat (2) @(negedge clk);
    test_reset;
    test_sll_srl;
    test_sra_rot;
    test_zero_shamt;
    test_reserved;
    test_back_to_back;
    test_reset_midflight;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
